// File: rtl/ce_divider_pkg.sv
// Shared types and helpers for the clock-enable divider bank.
// Counters are held at a fixed maximum width; channels zero-extend their CNT_W ratio into it.
package ce_divider_pkg;

  localparam int CNT_W_MAX = 16;

  typedef logic [CNT_W_MAX-1:0] cnt_t;

  typedef struct packed {
    cnt_t cnt;
    cnt_t cur;
    cnt_t pend_div;
    logic pend_v;
  } chan_state_t;

  // Ratios 0 and 1 both mean "enable every cycle".
  function automatic cnt_t eff(input cnt_t cur);
    return (cur <= cnt_t'(1)) ? cnt_t'(1) : cur;
  endfunction

  function automatic bit div_fits(input int div, input int cnt_w);
    return (cnt_w >= 1) && (cnt_w <= CNT_W_MAX) && (div >= 0) && (div < (1 << cnt_w));
  endfunction

endpackage

// File: rtl/ce_divider_if.sv
// Configuration port of the divider bank.
// cfg_valid/cfg_ready: a transfer happens on a rising clk edge where both are high; the master holds
// cfg_ch/cfg_div stable while cfg_valid is high until that edge. cfg_err pulses one cycle after a
// transfer that named a nonexistent channel.
interface ce_divider_if #(
  parameter int CH_W  = 1,
  parameter int CNT_W = 8
);
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_err;

  modport master (
    output cfg_valid, cfg_ch, cfg_div,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_div,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/ce_divider_chan.sv
// One clock-enable channel: modulo counter, pending-ratio register and glitch-free apply logic.
// A new ratio is only adopted at a terminal count or on sync_i, so no CE interval is ever truncated.
module ce_divider_chan
  import ce_divider_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sync_i,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             pend_v,
  output logic             ce
);

  // An out-of-range default falls back to "every cycle" rather than a truncated value.
  localparam cnt_t RST_DIV = div_fits(DEFAULT_DIV, CNT_W) ? cnt_t'(DEFAULT_DIV) : cnt_t'(1);

  chan_state_t st, st_nxt;
  cnt_t        eff_div, new_div;
  logic        tc, ce_nxt;

  assign eff_div = eff(st.cur);
  assign tc      = (st.cnt == eff_div - cnt_t'(1));
  assign new_div = cnt_t'(load_div);
  assign pend_v  = st.pend_v;

  always_comb begin
    st_nxt = st;
    ce_nxt = 1'b0;
    if (sync_i) begin
      st_nxt.cnt = '0;
      ce_nxt     = (eff_div == cnt_t'(1));
      if (load) begin
        st_nxt.cur    = new_div;
        st_nxt.pend_v = 1'b0;
      end else if (st.pend_v) begin
        st_nxt.cur    = st.pend_div;
        st_nxt.pend_v = 1'b0;
      end
    end else begin
      if (tc) begin
        st_nxt.cnt = '0;
        ce_nxt     = 1'b1;
        if (st.pend_v) begin
          st_nxt.cur    = st.pend_div;
          st_nxt.pend_v = 1'b0;
        end
      end else begin
        st_nxt.cnt = st.cnt + cnt_t'(1);
      end
      // load only arrives while pend_v is low, so it never collides with the apply above.
      if (load) begin
        st_nxt.pend_div = new_div;
        st_nxt.pend_v   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st <= '{cnt: '0, cur: RST_DIV, pend_div: '0, pend_v: 1'b0};
      ce <= 1'b0;
    end else begin
      st <= st_nxt;
      ce <= ce_nxt;
    end
  end

endmodule

// File: rtl/ce_divider_bank.sv
// Bank of NUM_CH runtime-programmable clock-enable generators driving BUFGCE.CE pins.
// Decodes configuration requests to channels and flags requests aimed at missing channels.
module ce_divider_bank
  import ce_divider_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2,
  parameter int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  ce_divider_if.slave       cfg,
  input  logic              sync_i,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] ce
);

  localparam int            CH_N     = 1 << CH_W;
  localparam logic [CH_W:0] NUM_CH_V = (CH_W + 1)'(NUM_CH);

  logic            ch_ok;
  logic            xfer;
  logic [CH_N-1:0] pend_pad;

  // Padding lets any cfg_ch value index safely; out-of-range channels never backpressure.
  assign pend_pad      = CH_N'(pending);
  assign ch_ok         = ({1'b0, cfg.cfg_ch} < NUM_CH_V);
  assign cfg.cfg_ready = ch_ok ? !pend_pad[cfg.cfg_ch] : 1'b1;
  assign xfer          = cfg.cfg_valid & cfg.cfg_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg.cfg_err <= 1'b0;
    end else begin
      cfg.cfg_err <= xfer & !ch_ok;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic load;
    assign load = xfer & ch_ok & (cfg.cfg_ch == CH_W'(i));

    ce_divider_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .sync_i   (sync_i),
      .load     (load),
      .load_div (cfg.cfg_div),
      .pend_v   (pending[i]),
      .ce       (ce[i])
    );
  end

endmodule
